stopwatch_display: RTL and testbench

Display back end for the stopwatch: it takes the binary minutes (0–99) and seconds (0–59) counts and drives a 4-digit, common-anode, time-multiplexed 7-segment display showing MM.SS.
- On a `sample` strobe it latches both counts and converts each to two BCD digits with a sequential double-dabble converter.
- It commits all four digits atomically and then scans them continuously at a parameterised refresh rate.
- It sits between the counter datapath and the board pins.

---
 rtl/stopwatch_display_pkg.sv | 47 ++++
 rtl/stopwatch_display_bin2bcd.sv | 37 +++
 rtl/stopwatch_display.sv | 142 ++++++++++++++
 tb/tb_stopwatch_display.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch display back end.
// Provides the scan index type, the converter FSM states, active-low 7-segment
// patterns (a..g, MSB = a), input limits and a digit-to-segment decoder.
package stopwatch_display_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  localparam logic [7:0] MAX_MIN = 8'd99;
  localparam logic [7:0] MAX_SEC = 8'd59;

  // Non-decimal nibbles can only come from out-of-range operands, which are
  // replaced by dashes anyway, so they fall back to the dash pattern.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to tens/ones BCD, one bit per step.
// Ports: clk, rst (sync, active-high), start (load bin, clear BCD), step
// (adjust+shift), bin in; tens/ones out. Result valid 8 steps after start; no backpressure.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] bin_q;
  logic [3:0] tens_adj;
  logic [3:0] ones_adj;

  assign ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
  assign tens_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (start) begin
      bin_q <= bin;
      tens  <= '0;
      ones  <= '0;
    end else if (step) begin
      // Hundreds digit is never needed for legal inputs, so the bit shifted
      // out of the tens nibble is simply discarded.
      {tens, ones, bin_q} <= {tens_adj[2:0], ones_adj, bin_q, 1'b0};
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS display driver: latches minutes/seconds on sample, converts to BCD and
// scans a 4-digit common-anode 7-segment display. Commit 9 cycles after sample;
// sample while busy is dropped. Ports: clk, rst, minutes, seconds, sample in;
// busy, done, an, seg, dp out (an/seg/dp active-low, registered).
import stopwatch_display_pkg::*;

module stopwatch_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       sample,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  state_t     state;
  state_t     state_nxt;
  logic       conv_start;
  logic       conv_step;
  logic       commit;
  logic [2:0] shift_cnt;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  // Display digits, index 0 = seconds ones ... index 3 = minutes tens.
  logic [3:0][3:0] digits;
  logic            dash;

  logic [CW-1:0] ref_cnt;
  digit_idx_t    idx;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    conv_step  = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (sample) begin
          conv_start = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        conv_step = 1'b1;
        if (shift_cnt == 3'd7) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      done      <= 1'b0;
      digits    <= '0;
      dash      <= 1'b0;
    end else begin
      done <= commit;
      if (conv_start) begin
        min_q     <= minutes;
        sec_q     <= seconds;
        shift_cnt <= '0;
      end else if (conv_step) begin
        shift_cnt <= shift_cnt + 3'd1;
      end
      // All four digits and the dash flag change together so the scanner
      // never shows a mix of old and new values.
      if (commit) begin
        digits <= {min_tens, min_ones, sec_tens, sec_ones};
        dash   <= (min_q > MAX_MIN) || (sec_q > MAX_SEC);
      end
    end
  end

  bin2bcd_seq u_min_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .step  (conv_step),
    .bin   (minutes),
    .tens  (min_tens),
    .ones  (min_ones)
  );

  bin2bcd_seq u_sec_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .step  (conv_step),
    .bin   (seconds),
    .tens  (sec_tens),
    .ones  (sec_ones)
  );

  // ---------------- scanner ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= 4'b1110;
      seg     <= SEG_0;
      dp      <= 1'b1;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CW'(1);
      end
      // Pins follow the index register one cycle later.
      an  <= ~(4'b0001 << idx);
      seg <= dash ? SEG_DASH : seg_encode(digits[idx]);
      dp  <= (idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with REFRESH_DIV=4: stimulus pushes the
// expected four segment patterns per conversion, a monitor pops one on each
// done pulse and checks a full scan frame from the pins.
module tb_stopwatch_display;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sample;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  // Packed {idx3, idx2, idx1, idx0} segment patterns.
  logic [27:0] exp_q[$];

  always #5 clk = ~clk;

  stopwatch_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .minutes (minutes),
    .seconds (seconds),
    .sample  (sample),
    .busy    (busy),
    .done    (done),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples 16 cycles (one full frame) and checks every digit shown.
  task automatic check_frame(input string tag, input logic [27:0] e);
    int i;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: i = 0;
        4'b1101: i = 1;
        4'b1011: i = 2;
        4'b0111: i = 3;
        default: i = -1;
      endcase
      chk({tag, " an_onehot"}, 32'(i >= 0), 32'd1);
      if (i >= 0) begin
        chk({tag, " seg"}, 32'(seg), 32'(e[i*7 +: 7]));
        chk({tag, " dp"}, 32'(dp), (i == 2) ? 32'd0 : 32'd1);
      end
    end
  endtask

  // Monitor: consumes one expected frame per done pulse.
  initial begin
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("done_width", 32'(done), 32'd0);
          check_frame("disp", e);
        end
      end
    end
  end

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk({tag, " busy_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic convert(input logic [7:0] m, input logic [7:0] s, input logic [27:0] e);
    int n;
    @(negedge clk);
    minutes = m;
    seconds = s;
    sample  = 1'b1;
    exp_q.push_back(e);
    push_cnt++;
    @(negedge clk);
    sample = 1'b0;
    wait_idle("convert", n);
    chk("busy_len", 32'(n), 32'd9);
    repeat (24) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    logic [3:0] ea;
    rst     = 1'b1;
    sample  = 1'b0;
    minutes = 8'd0;
    seconds = 8'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst an", 32'(an), 32'b1110);
    chk("rst seg", 32'(seg), 32'(S0));
    chk("rst dp", 32'(dp), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;

    // Anode stepping: each digit held 4 cycles, one cycle of pin latency.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ea = ~(4'b0001 << ((k - 1) / 4));
      chk("scan an", 32'(an), 32'(ea));
      chk("scan dp", 32'(dp), (((k - 1) / 4) == 2) ? 32'd0 : 32'd1);
    end

    convert(8'd59,  8'd7,  {S5, S9, S0, S7});
    convert(8'd99,  8'd59, {S9, S9, S5, S9});
    convert(8'd0,   8'd0,  {S0, S0, S0, S0});
    convert(8'd10,  8'd10, {S1, S0, S1, S0});
    convert(8'd100, 8'd30, {SD, SD, SD, SD});

    // Second strobe three cycles into a conversion is dropped.
    @(negedge clk);
    minutes = 8'd12;
    seconds = 8'd34;
    sample  = 1'b1;
    exp_q.push_back({S1, S2, S3, S4});
    push_cnt++;
    @(negedge clk);
    sample = 1'b0;
    repeat (2) @(negedge clk);
    minutes = 8'd56;
    seconds = 8'd0;
    sample  = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    wait_idle("ignored", n);
    repeat (24) @(negedge clk);

    // Reset at edge T+4 of a 42:42 conversion.
    d0 = done_cnt;
    @(negedge clk);
    minutes = 8'd42;
    seconds = 8'd42;
    sample  = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    check_frame("abort disp", {S0, S0, S0, S0});
    chk("abort busy_after", 32'(busy), 32'd0);
    chk("abort no_done", 32'(done_cnt), 32'(d0));

    repeat (30) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(push_cnt));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
